// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg
//
// Shared types and sizes for the instruction-memory arbiter slice.
// ADDR_WIDTH is the byte-address width of the instruction memory, and
// SIM_MEM_SIZE is the size in bytes of the simulation memory model.
// The two enums name the bus direction and the port that won arbitration.
package imem_arbiter_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int SIM_MEM_SIZE = 1024;

    typedef enum logic {IMEM_RD, IMEM_WR} imem_dir_t;
    typedef enum logic {OWN_FETCH, OWN_LOAD} imem_owner_t;

    // A word access is legal only when the two byte-offset bits are zero.
    function automatic logic isWordAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
//
// Request/response bundle for the two requesters of the instruction memory.
// Signal suffixes are written from the arbiter's point of view: _i signals
// are driven by the requesters, _o signals are driven by the arbiter.
//
//   fetch_req_i / fetch_addr_i            fetch read request and byte address
//   fetch_gnt_o                           fetch request accepted this cycle
//   fetch_rvalid_o / fetch_rdata_o        fetch read response
//   fetch_err_o                           misaligned fetch, valid with rvalid
//   load_req_i / load_we_i                loader request, 1 = write
//   load_addr_i / load_wdata_i            loader byte address and write data
//   load_gnt_o                            loader request accepted this cycle
//   load_rvalid_o / load_rdata_o          loader read response
//   load_err_o                            misaligned loader access, one cycle after grant
//
// Modport master is the requester side, modport slave is the arbiter side.
interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    logic                  fetch_req_i;
    logic [ADDR_WIDTH-1:0] fetch_addr_i;
    logic                  fetch_gnt_o;
    logic                  fetch_rvalid_o;
    logic [31:0]           fetch_rdata_o;
    logic                  fetch_err_o;

    logic                  load_req_i;
    logic                  load_we_i;
    logic [ADDR_WIDTH-1:0] load_addr_i;
    logic [31:0]           load_wdata_i;
    logic                  load_gnt_o;
    logic                  load_rvalid_o;
    logic [31:0]           load_rdata_o;
    logic                  load_err_o;

    modport master (
        output fetch_req_i, fetch_addr_i,
        output load_req_i, load_we_i, load_addr_i, load_wdata_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        input  load_gnt_o, load_rvalid_o, load_rdata_o, load_err_o
    );

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        input  load_req_i, load_we_i, load_addr_i, load_wdata_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        output load_gnt_o, load_rvalid_o, load_rdata_o, load_err_o
    );

endinterface

// File: rtl/imem_arbiter_fair_pick.sv
// imem_fair_pick
//
// Priority chooser between the fetch and loader ports. The loader normally
// wins, but a run of loader grants while fetch is waiting is counted, and
// once the run reaches STARVE_LIMIT the fetch port wins the next cycle in
// which a grant is possible.
//
//   clk, rst          clock and synchronous active-high reset
//   fetch_req_i       fetch port is requesting
//   load_req_i        loader port is requesting
//   fetch_gnt_i       fetch port was actually granted this cycle
//   load_gnt_i        loader port was actually granted this cycle
//   winner_o          port that would be granted if a grant is possible
//   winner_valid_o    at least one port is requesting
module imem_fair_pick
    import imem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_i,
    input  logic        load_req_i,
    input  logic        fetch_gnt_i,
    input  logic        load_gnt_i,
    output imem_owner_t winner_o,
    output logic        winner_valid_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starveCnt_q;
    logic [CW-1:0] starveCnt_d;

    // Pick the winner from the current requests. Fetch only beats a
    // requesting loader once the loader has used up its run of grants.
    always_comb begin
        winner_o       = OWN_LOAD;
        winner_valid_o = fetch_req_i | load_req_i;
        if (fetch_req_i && (!load_req_i || (starveCnt_q == LIMIT))) begin
            winner_o = OWN_FETCH;
        end
    end

    // Track the length of the current run of loader grants that happened
    // while fetch was waiting. Any fetch grant, or fetch dropping its
    // request, ends the run. The count sticks at the limit instead of
    // wrapping, so a turnaround cycle cannot lose the fetch's turn.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!fetch_req_i || fetch_gnt_i) begin
            starveCnt_d = '0;
        end else if (load_gnt_i && (starveCnt_q != LIMIT)) begin
            starveCnt_d = starveCnt_q + CW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//
// Shares one single-ported instruction memory between the CPU fetch port
// (read only) and the program-loader/debug port (read or write). The arbiter
// owns the direction of the bidirectional data bus, inserts one idle cycle
// when the bus turns from write back to read, flags misaligned accesses
// without touching memory, and bounds how long fetch can be starved.
//
//   clk, rst      clock and synchronous active-high reset
//   req_if        requester bundle (slave side), see imem_arbiter_if
//   mem_addr_o    memory byte address, zero when nothing is granted
//   mem_re_o      memory read strobe
//   mem_we_o      memory write strobe
//   mem_bus_io    bidirectional data bus, driven only while writing
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_arbiter_if.slave         req_if,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    inout  wire  [31:0]           mem_bus_io
);

    imem_dir_t             dirState_q;
    imem_owner_t           winner;
    logic                  winnerValid;
    logic                  winnerIsWrite;
    logic                  canGrant;
    logic                  fetchGnt;
    logic                  loadGnt;
    logic [ADDR_WIDTH-1:0] gntAddr;
    logic                  gntAligned;

    logic                  fetchRvalid_q;
    logic                  fetchErr_q;
    logic [31:0]           fetchRdata_q;
    logic                  loadRvalid_q;
    logic                  loadErr_q;
    logic [31:0]           loadRdata_q;

    imem_fair_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk            (clk),
        .rst            (rst),
        .fetch_req_i    (req_if.fetch_req_i),
        .load_req_i     (req_if.load_req_i),
        .fetch_gnt_i    (fetchGnt),
        .load_gnt_i     (loadGnt),
        .winner_o       (winner),
        .winner_valid_o (winnerValid)
    );

    // Decide whether the winner is granted this cycle and steer its request
    // onto the memory. Right after a write the bus may still be driven, so
    // only another write may go in that cycle; a read winner waits one
    // cycle. Misaligned accesses are granted but raise no strobe, and reset
    // blocks everything combinationally.
    always_comb begin
        winnerIsWrite = (winner == OWN_LOAD) && req_if.load_we_i;
        canGrant      = !rst && winnerValid &&
                        ((dirState_q == IMEM_RD) || winnerIsWrite);
        fetchGnt      = canGrant && (winner == OWN_FETCH);
        loadGnt       = canGrant && (winner == OWN_LOAD);
        gntAddr       = (winner == OWN_FETCH) ? req_if.fetch_addr_i
                                              : req_if.load_addr_i;
        gntAligned    = isWordAligned(gntAddr[1:0]);
        mem_re_o      = canGrant && gntAligned && !winnerIsWrite;
        mem_we_o      = canGrant && gntAligned && winnerIsWrite;
        mem_addr_o    = canGrant ? gntAddr : '0;
    end

    assign mem_bus_io = mem_we_o ? req_if.load_wdata_i : 'z;

    assign req_if.fetch_gnt_o    = fetchGnt;
    assign req_if.load_gnt_o     = loadGnt;
    assign req_if.fetch_rvalid_o = fetchRvalid_q;
    assign req_if.fetch_err_o    = fetchErr_q;
    assign req_if.fetch_rdata_o  = fetchRdata_q;
    assign req_if.load_rvalid_o  = loadRvalid_q;
    assign req_if.load_err_o     = loadErr_q;
    assign req_if.load_rdata_o   = loadRdata_q;

    // Bus-direction FSM. A cycle that actually drove write data leaves the
    // bus in write mode; any other cycle returns it to read mode, which is
    // what makes the single turnaround cycle after a write. Misaligned
    // writes never drive the bus, so they never enter write mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            dirState_q <= IMEM_RD;
        end else begin
            case (dirState_q)
                IMEM_RD: begin
                    if (mem_we_o) begin
                        dirState_q <= IMEM_WR;
                    end
                end
                IMEM_WR: begin
                    if (!mem_we_o) begin
                        dirState_q <= IMEM_RD;
                    end
                end
                default: dirState_q <= IMEM_RD;
            endcase
        end
    end

    // Response registers. Read data is taken off the bus at the edge that
    // ends the grant cycle and held until that port's next read response.
    // Misaligned reads return zero data with the error flag set; the loader
    // error flag also pulses for misaligned writes, which have no rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchRvalid_q <= 1'b0;
            fetchErr_q    <= 1'b0;
            fetchRdata_q  <= '0;
            loadRvalid_q  <= 1'b0;
            loadErr_q     <= 1'b0;
            loadRdata_q   <= '0;
        end else begin
            fetchRvalid_q <= fetchGnt;
            fetchErr_q    <= fetchGnt && !gntAligned;
            loadRvalid_q  <= loadGnt && !req_if.load_we_i;
            loadErr_q     <= loadGnt && !gntAligned;
            if (fetchGnt) begin
                fetchRdata_q <= gntAligned ? mem_bus_io : '0;
            end
            if (loadGnt && !req_if.load_we_i) begin
                loadRdata_q <= gntAligned ? mem_bus_io : '0;
            end
        end
    end

endmodule
